// File: rtl/fifo_rd_stream_if.sv
// fifo_rd_stream_if: valid/ready byte stream from the FIFO drain engine to the
// downstream serializer.
//   tdata_o  : stream word (buffer head), master -> slave
//   tvalid_o : stream valid, master -> slave
//   tready_i : downstream ready, slave -> master
//   tlast_o  : final word of a burst, master -> slave
//              (present only when FIFO_RD_STREAM_TLAST_EN is defined)
interface fifo_rd_stream_if #(
  parameter int unsigned DATASIZE = 8
) ();

  logic [DATASIZE-1:0] tdata_o;
  logic                tvalid_o;
  logic                tready_i;
`ifdef FIFO_RD_STREAM_TLAST_EN
  logic                tlast_o;
`endif

`ifdef FIFO_RD_STREAM_TLAST_EN
  modport master (output tdata_o, output tvalid_o, output tlast_o, input tready_i);
  modport slave  (input tdata_o, input tvalid_o, input tlast_o, output tready_i);
`else
  modport master (output tdata_o, output tvalid_o, input tready_i);
  modport slave  (input tdata_o, input tvalid_o, output tready_i);
`endif

endinterface

// File: rtl/fifo_rd_stream.sv
// fifo_rd_stream: read-domain drain engine. On start it pops len_i words from
// a first-word-fall-through FIFO read port and streams them out through a
// 2-entry buffer on a valid/ready interface.
// Optional feature macro: FIFO_RD_STREAM_TLAST_EN (adds tlast on the stream).
//   rclk_i, rrst_ni     : read clock, async active-low reset
//   start_i, len_i      : start a burst of len_i words (sampled in IDLE)
//   abort_i             : end the current burst early (sampled in RUN)
//   busy_o, done_o      : burst in progress / one-cycle end-of-burst pulse
//   rempty_i, rdata_i   : FIFO empty flag and head word
//   rinc_o              : pop the FIFO head on this edge
//   strm                : output stream (tdata/tvalid/tready[/tlast])
module fifo_rd_stream #(
  parameter int unsigned DATASIZE = 8,
  parameter int unsigned LENSIZE  = 8
) (
  input  logic                rclk_i,
  input  logic                rrst_ni,
  input  logic                start_i,
  input  logic [LENSIZE-1:0]  len_i,
  input  logic                abort_i,
  output logic                busy_o,
  output logic                done_o,
  input  logic                rempty_i,
  input  logic [DATASIZE-1:0] rdata_i,
  output logic                rinc_o,
  fifo_rd_stream_if.master    strm
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic [LENSIZE-1:0]  pop_left_q, pop_left_d;
  logic [LENSIZE-1:0]  send_left_q, send_left_d;
  logic [1:0]          occ_q;
  logic                rd_ptr_q, wr_ptr_q;
  logic [DATASIZE-1:0] mem_q [2];
  logic                busy_q, done_q;
  logic                flush;
  logic                push;
  logic                hs;

  // FIFO pop: never depends on downstream ready, suppressed by abort
  assign rinc_o = (state_q == RUN) && !abort_i && !rempty_i &&
                  (pop_left_q != '0) && (occ_q != 2'd2);
  assign push   = rinc_o;
  assign hs     = strm.tvalid_o && strm.tready_i;

  assign strm.tvalid_o = (occ_q != 2'd0);
  assign strm.tdata_o  = mem_q[rd_ptr_q];
  assign busy_o        = busy_q;
  assign done_o        = done_q;

`ifdef FIFO_RD_STREAM_TLAST_EN
  // occ is zero after an abort, so tlast can only mark a normal final word
  assign strm.tlast_o  = strm.tvalid_o && (send_left_q == LENSIZE'(1));
`endif

  // Next-state and counter update
  always_comb begin
    state_d     = state_q;
    pop_left_d  = pop_left_q;
    send_left_d = send_left_q;
    flush       = 1'b0;
    case (state_q)
      IDLE: begin
        if (start_i) begin
          if (len_i != '0) begin
            state_d     = RUN;
            pop_left_d  = len_i;
            send_left_d = len_i;
          end else begin
            state_d = DONE;
          end
        end
      end
      RUN: begin
        if (abort_i) begin
          state_d = DONE;
          flush   = 1'b1;
        end else begin
          if (push) pop_left_d = pop_left_q - LENSIZE'(1);
          if (hs) begin
            send_left_d = send_left_q - LENSIZE'(1);
            if (send_left_q == LENSIZE'(1)) state_d = DONE;
          end
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State, counters and status flags
  always_ff @(posedge rclk_i or negedge rrst_ni) begin
    if (!rrst_ni) begin
      state_q     <= IDLE;
      pop_left_q  <= '0;
      send_left_q <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      pop_left_q  <= pop_left_d;
      send_left_q <= send_left_d;
      busy_q      <= (state_d == RUN);
      done_q      <= (state_d == DONE);
    end
  end

  // 2-entry output buffer; simultaneous push/pop keeps occupancy and order
  always_ff @(posedge rclk_i or negedge rrst_ni) begin
    if (!rrst_ni) begin
      occ_q    <= 2'd0;
      rd_ptr_q <= 1'b0;
      wr_ptr_q <= 1'b0;
      mem_q[0] <= '0;
      mem_q[1] <= '0;
    end else if (flush) begin
      occ_q    <= 2'd0;
      rd_ptr_q <= wr_ptr_q;
    end else begin
      if (push) begin
        mem_q[wr_ptr_q] <= rdata_i;
        wr_ptr_q        <= ~wr_ptr_q;
      end
      if (hs) rd_ptr_q <= ~rd_ptr_q;
      case ({push, hs})
        2'b10:   occ_q <= occ_q + 2'd1;
        2'b01:   occ_q <= occ_q - 2'd1;
        default: occ_q <= occ_q;
      endcase
    end
  end

endmodule

// File: tb/tb_fifo_rd_stream.sv
// tb_fifo_rd_stream: directed bench for fifo_rd_stream with a FIFO model and a
// scoreboard of words popped from the FIFO that must appear on the stream.
module tb_fifo_rd_stream;

  logic       clk = 1'b0;
  logic       rrst_n;
  logic       start;
  logic [7:0] len;
  logic       abort;
  logic       busy;
  logic       done;
  logic       rempty;
  logic [7:0] rdata;
  logic       rinc;

  fifo_rd_stream_if #(.DATASIZE(8)) s_if ();

  fifo_rd_stream #(.DATASIZE(8), .LENSIZE(8)) dut (
    .rclk_i   (clk),
    .rrst_ni  (rrst_n),
    .start_i  (start),
    .len_i    (len),
    .abort_i  (abort),
    .busy_o   (busy),
    .done_o   (done),
    .rempty_i (rempty),
    .rdata_i  (rdata),
    .rinc_o   (rinc),
    .strm     (s_if)
  );

  always #5 clk = ~clk;

  logic [7:0] fifo_q [$];
  logic [7:0] exp_q  [$];
  int checks = 0;
  int errors = 0;
  int cyc_idx = 0;
  int hs_cnt, pop_cnt, done_cnt, busy_cnt, done_cyc, last_hs, burst_len;
  logic obs_rinc, obs_busy, obs_done, obs_tvalid;
  logic [7:0] obs_tdata;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic clr_stats(input int blen);
    hs_cnt = 0; pop_cnt = 0; done_cnt = 0; busy_cnt = 0;
    done_cyc = -1; last_hs = -1; burst_len = blen;
  endtask

  // One clock: refresh FIFO model at negedge, observe/score, return after posedge
  task automatic cyc();
    logic [7:0] w;
    @(negedge clk);
    rempty = (fifo_q.size() == 0);
    rdata  = rempty ? 8'h00 : fifo_q[0];
    #1;
    cyc_idx++;
    obs_rinc = rinc; obs_busy = busy; obs_done = done;
    obs_tvalid = s_if.tvalid_o; obs_tdata = s_if.tdata_o;
    if (rrst_n) begin
      check("tvalid", 32'(s_if.tvalid_o), 32'(exp_q.size() != 0));
`ifdef FIFO_RD_STREAM_TLAST_EN
      check("tlast", 32'(s_if.tlast_o),
            32'((exp_q.size() != 0) && (hs_cnt == burst_len - 1)));
`endif
      if (s_if.tvalid_o && s_if.tready_i) begin
        if (exp_q.size() == 0) check("hs_extra_word", 32'(1), 32'(0));
        else begin
          w = exp_q.pop_front();
          check("tdata", 32'(s_if.tdata_o), 32'(w));
        end
        hs_cnt++;
        last_hs = cyc_idx;
      end
      if (rinc) begin
        if (fifo_q.size() == 0) check("rinc_when_empty", 32'(1), 32'(0));
        else exp_q.push_back(fifo_q.pop_front());
        pop_cnt++;
      end
      if (abort && busy) exp_q.delete();
      if (done) begin done_cnt++; done_cyc = cyc_idx; end
      if (busy) busy_cnt++;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic preload(input logic [7:0] base, input int n);
    fifo_q.delete();
    for (int i = 0; i < n; i++) fifo_q.push_back(8'(base + 8'(i)));
  endtask

  initial begin
    rrst_n = 1'b0; start = 1'b0; len = 8'd0; abort = 1'b0;
    rempty = 1'b1; rdata = 8'h00; s_if.tready_i = 1'b0;
    clr_stats(0);

    // Reset state
    #12;
    check("rst_busy", 32'(busy), 32'(0));
    check("rst_done", 32'(done), 32'(0));
    check("rst_tvalid", 32'(s_if.tvalid_o), 32'(0));
    check("rst_tdata", 32'(s_if.tdata_o), 32'(0));
    check("rst_rinc", 32'(rinc), 32'(0));
    @(negedge clk); rrst_n = 1'b1;
    @(posedge clk); #1;

    // Normal burst A1..A4
    preload(8'hA1, 4); clr_stats(4);
    s_if.tready_i = 1'b1; start = 1'b1; len = 8'd4;
    cyc();
    check("norm_idle_busy", 32'(obs_busy), 32'(0));
    check("norm_idle_rinc", 32'(obs_rinc), 32'(0));
    start = 1'b0;
    repeat (12) cyc();
    check("norm_hs", 32'(hs_cnt), 32'(4));
    check("norm_pops", 32'(pop_cnt), 32'(4));
    check("norm_done_cnt", 32'(done_cnt), 32'(1));
    check("norm_done_cyc", 32'(done_cyc), 32'(last_hs + 1));

    // Backpressure
    preload(8'hB1, 3); clr_stats(3);
    s_if.tready_i = 1'b0; start = 1'b1; len = 8'd3;
    cyc();
    start = 1'b0;
    repeat (5) cyc();
    check("bp_pops", 32'(pop_cnt), 32'(2));
    check("bp_rinc", 32'(obs_rinc), 32'(0));
    check("bp_tdata", 32'(obs_tdata), 32'(8'hB1));
    check("bp_tvalid", 32'(obs_tvalid), 32'(1));
    s_if.tready_i = 1'b1;
    repeat (10) cyc();
    check("bp_hs", 32'(hs_cnt), 32'(3));
    check("bp_pops_total", 32'(pop_cnt), 32'(3));
    check("bp_done_cnt", 32'(done_cnt), 32'(1));

    // Starved FIFO
    fifo_q.delete(); clr_stats(2);
    start = 1'b1; len = 8'd2;
    cyc();
    start = 1'b0;
    for (int i = 0; i < 10; i++) begin
      cyc();
      check("starve_rinc", 32'(obs_rinc), 32'(0));
      check("starve_busy", 32'(obs_busy), 32'(1));
    end
    fifo_q.push_back(8'hC1); fifo_q.push_back(8'hC2);
    repeat (10) cyc();
    check("starve_hs", 32'(hs_cnt), 32'(2));
    check("starve_done_cnt", 32'(done_cnt), 32'(1));

    // Zero length
    preload(8'hE0, 2); clr_stats(0);
    start = 1'b1; len = 8'd0;
    cyc();
    start = 1'b0;
    cyc();
    check("zero_done", 32'(obs_done), 32'(1));
    check("zero_busy", 32'(obs_busy), 32'(0));
    repeat (4) cyc();
    check("zero_busy_cnt", 32'(busy_cnt), 32'(0));
    check("zero_pops", 32'(pop_cnt), 32'(0));
    check("zero_done_cnt", 32'(done_cnt), 32'(1));

    // Abort after 3 handshakes
    preload(8'hD0, 8); clr_stats(8);
    s_if.tready_i = 1'b1; start = 1'b1; len = 8'd8;
    cyc();
    start = 1'b0;
    for (int i = 0; i < 30 && hs_cnt < 3; i++) cyc();
    check("abort_reach_3hs", 32'(hs_cnt), 32'(3));
    abort = 1'b1;
    cyc();
    check("abort_rinc", 32'(obs_rinc), 32'(0));
    abort = 1'b0;
    cyc();
    check("abort_tvalid", 32'(obs_tvalid), 32'(0));
    check("abort_done", 32'(obs_done), 32'(1));
    check("abort_pops_le5", 32'(pop_cnt <= 5), 32'(1));
    check("abort_fifo_ge3", 32'(fifo_q.size() >= 3), 32'(1));
    repeat (3) cyc();
    check("abort_done_cnt", 32'(done_cnt), 32'(1));

    // start during RUN is ignored
    preload(8'h61, 4); clr_stats(4);
    s_if.tready_i = 1'b0; start = 1'b1; len = 8'd4;
    cyc();
    start = 1'b0;
    cyc();
    start = 1'b1; len = 8'd7;
    cyc();
    start = 1'b0; s_if.tready_i = 1'b1;
    repeat (12) cyc();
    check("ign_hs", 32'(hs_cnt), 32'(4));
    check("ign_pops", 32'(pop_cnt), 32'(4));
    check("ign_done_cnt", 32'(done_cnt), 32'(1));

    // Reset mid-burst, then a fresh burst
    preload(8'h71, 4); clr_stats(4);
    s_if.tready_i = 1'b0; start = 1'b1; len = 8'd4;
    cyc();
    start = 1'b0;
    repeat (3) cyc();
    check("mid_pre_busy", 32'(obs_busy), 32'(1));
    rrst_n = 1'b0;
    #1;
    check("mid_rst_busy", 32'(busy), 32'(0));
    check("mid_rst_tvalid", 32'(s_if.tvalid_o), 32'(0));
    check("mid_rst_tdata", 32'(s_if.tdata_o), 32'(0));
    check("mid_rst_rinc", 32'(rinc), 32'(0));
    check("mid_rst_done", 32'(done), 32'(0));
    exp_q.delete();
    cyc();
    rrst_n = 1'b1;
    preload(8'h81, 2); clr_stats(2);
    s_if.tready_i = 1'b1; start = 1'b1; len = 8'd2;
    cyc();
    start = 1'b0;
    repeat (8) cyc();
    check("post_rst_hs", 32'(hs_cnt), 32'(2));
    check("post_rst_done_cnt", 32'(done_cnt), 32'(1));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
